// File: rtl/radiant_trigger_governor_mc_if.sv
// Trigger/readout handshake bundle between the governor and the LAB4 readout side.
interface radiant_trigger_governor_mc_if #(
    parameter int NUM_SRC = 6
) ();
    logic               trig_o;
    logic [NUM_SRC-1:0] trig_mask_o;
    logic [31:0]        trig_num_o;
    logic               readout_done_i;
    logic               readout_full_i;

    // Governor side: issues triggers, observes readout progress.
    modport master (
        output trig_o,
        output trig_mask_o,
        output trig_num_o,
        input  readout_done_i,
        input  readout_full_i
    );

    // Readout/DMA side: consumes triggers, reports completion and back-pressure.
    modport slave (
        input  trig_o,
        input  trig_mask_o,
        input  trig_num_o,
        output readout_done_i,
        output readout_full_i
    );
endinterface

// File: rtl/radiant_trigger_governor_mc.sv
// Multi-source trigger governor: qualifies and prescales trigger flags, arbitrates
// them into one numbered trigger pulse, limits outstanding events, and accounts
// dead triggers and busy time per PPS second.
module radiant_trigger_governor_mc #(
    parameter int NUM_SRC       = 6,
    parameter int EV_DEPTH      = 4,
    parameter int PRESCALE_BITS = 8,
    parameter int HOLDOFF_BITS  = 16,
    parameter int PPS_SRC       = 4,
    localparam int OUT_W        = $clog2(EV_DEPTH + 1)
) (
    input  logic                             sys_clk_i,
    input  logic                             rst_i,
    input  logic                             run_i,
    input  logic                             en_i,
    input  logic [NUM_SRC-1:0]               src_i,
    input  logic [NUM_SRC-1:0]               src_en_i,
    input  logic [NUM_SRC*PRESCALE_BITS-1:0] prescale_i,
    input  logic [HOLDOFF_BITS-1:0]          holdoff_i,
    input  logic                             pps_i,
    radiant_trigger_governor_mc_if.master    bus,
    output logic                             busy_o,
    output logic [OUT_W-1:0]                 outstanding_o,
    output logic                             trig_done_o,
    output logic                             dead_o,
    output logic [15:0]                      dead_count_o,
    output logic [31:0]                      deadtime_o
);

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_ARMED    = 2'd1,
        S_HOLDOFF  = 2'd2,
        S_BLOCKED  = 2'd3
    } state_t;

    localparam logic [OUT_W-1:0] DEPTH = OUT_W'(EV_DEPTH);

    state_t                  state_q;
    logic                    active_q;
    logic [NUM_SRC-1:0]      q_q;
    logic [HOLDOFF_BITS-1:0] hold_q;
    logic [31:0]             ev_cnt_q;
    logic                    trig_q;
    logic [NUM_SRC-1:0]      mask_q;
    logic [31:0]             num_q;
    logic                    busy_q;
    logic [OUT_W-1:0]        outst_q;
    logic [OUT_W-1:0]        outst_d;
    logic                    trig_done_q;
    logic                    dead_q;
    logic [15:0]             dc_run_q;
    logic [15:0]             dc_run_d;
    logic [15:0]             dc_out_q;
    logic [31:0]             dt_acc_q;
    logic [31:0]             dt_acc_d;
    logic [31:0]             dt_out_q;

    logic                    eval_en;
    logic [NUM_SRC-1:0]      accept;
    logic                    any_acc;
    logic                    dead_now;
    logic                    room;

    // Prescalers only run while the governor can actually take a trigger; a full
    // event window (reachable straight out of DISABLED) also stops evaluation.
    assign room    = (outst_q != DEPTH);
    assign eval_en = active_q && (state_q == S_ARMED) && room;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            localparam bit IS_PPS = (gi == PPS_SRC);
            logic [PRESCALE_BITS-1:0] cnt_q;
            logic                     hit;

            assign hit        = (cnt_q == prescale_i[gi*PRESCALE_BITS +: PRESCALE_BITS]);
            assign accept[gi] = eval_en && q_q[gi] && (IS_PPS || hit);

            // Per-source 1-of-(P+1) prescale counter; the PPS source bypasses it.
            always_ff @(posedge sys_clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else if (eval_en && q_q[gi] && !IS_PPS) begin
                    cnt_q <= hit ? '0 : cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    assign any_acc  = |accept;
    assign dead_now = active_q && ((state_q == S_HOLDOFF) || (state_q == S_BLOCKED)) && (|q_q);

    // Outstanding-event bookkeeping: accept and done in one cycle cancel out.
    always_comb begin
        outst_d = outst_q;
        if (any_acc && !bus.readout_done_i) begin
            outst_d = outst_q + 1'b1;
        end else if (!any_acc && bus.readout_done_i && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end
    end

    // Running dead-trigger and busy-cycle counts including the current cycle.
    always_comb begin
        dc_run_d = dc_run_q;
        if (dead_now && (dc_run_q != 16'hFFFF)) begin
            dc_run_d = dc_run_q + 16'd1;
        end
        dt_acc_d = dt_acc_q + {31'd0, busy_q};
    end

    // Enable lag register and source qualification stage.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            q_q      <= '0;
        end else begin
            active_q <= run_i & en_i;
            q_q      <= src_i & src_en_i & {NUM_SRC{active_q}};
        end
    end

    // Governor FSM with registered trigger, busy and dead outputs.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q  <= S_DISABLED;
            hold_q   <= '0;
            ev_cnt_q <= '0;
            trig_q   <= 1'b0;
            mask_q   <= '0;
            num_q    <= '0;
            busy_q   <= 1'b0;
            dead_q   <= 1'b0;
        end else begin
            trig_q <= any_acc;
            dead_q <= dead_now;
            if (any_acc) begin
                mask_q   <= accept;
                num_q    <= ev_cnt_q;
                ev_cnt_q <= ev_cnt_q + 32'd1;
            end
            if (!active_q) begin
                state_q <= S_DISABLED;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_DISABLED: begin
                        state_q <= S_ARMED;
                        busy_q  <= 1'b0;
                    end
                    S_ARMED: begin
                        if (any_acc) begin
                            state_q <= S_HOLDOFF;
                            hold_q  <= holdoff_i;
                            busy_q  <= 1'b1;
                        end else if (bus.readout_full_i || !room) begin
                            state_q <= S_BLOCKED;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_HOLDOFF: begin
                        if (hold_q == '0) begin
                            if (!room || bus.readout_full_i) begin
                                state_q <= S_BLOCKED;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= S_ARMED;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                    default: begin
                        if (room && !bus.readout_full_i) begin
                            state_q <= S_ARMED;
                            busy_q  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // Outstanding count, drain pulse and per-PPS-second accounting.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            outst_q     <= '0;
            trig_done_q <= 1'b0;
            dc_run_q    <= '0;
            dc_out_q    <= '0;
            dt_acc_q    <= '0;
            dt_out_q    <= '0;
        end else begin
            outst_q     <= outst_d;
            trig_done_q <= (outst_q != '0) && (outst_d == '0);
            if (pps_i) begin
                dc_out_q <= dc_run_d;
                dc_run_q <= {15'd0, dead_now};
                dt_out_q <= dt_acc_d;
                dt_acc_q <= {31'd0, busy_q};
            end else begin
                dc_run_q <= dc_run_d;
                dt_acc_q <= dt_acc_d;
            end
        end
    end

    assign bus.trig_o      = trig_q;
    assign bus.trig_mask_o = mask_q;
    assign bus.trig_num_o  = num_q;
    assign busy_o          = busy_q;
    assign outstanding_o   = outst_q;
    assign trig_done_o     = trig_done_q;
    assign dead_o          = dead_q;
    assign dead_count_o    = dc_out_q;
    assign deadtime_o      = dt_out_q;

endmodule
